// File: rtl/mfe_led7seg_pkg.sv
// Shared definitions for the 74HC595 7-segment scanner: width helper, FSM state
// encoding and pin-polarity helper.
package mfe_led7seg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SH_LO,
    ST_SH_HI,
    ST_LATCH,
    ST_DWELL
  } state_e;

  // Number of bits needed to hold 'value' itself (not value-1), minimum 1.
  function automatic int clogb2(input int value);
    int r = 0;
    for (int v = value; v > 0; v = v >> 1) r++;
    return (r < 1) ? 1 : r;
  endfunction

  function automatic logic pol_bit(input logic lit, input logic act_low);
    return lit ^ act_low;
  endfunction

endpackage

// File: rtl/mfe_74hc595_shifter.sv
// Generic W-bit MSB-first serialiser for a 74HC595 chain: SH_LO/SH_HI per bit,
// then one LATCH phase; pins are registered so sclk/rclk never glitch.
module mfe_74hc595_shifter
  import mfe_led7seg_pkg::*;
#(
  parameter int W       = 16,
  parameter int CLK_DIV = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] word,
  output logic         done,
  output logic         sclk,
  output logic         rclk,
  output logic         dio
);

  localparam int DW = clogb2(CLK_DIV);
  localparam int BW = clogb2(W);

  state_e         state_q, state_d;
  logic [DW-1:0]  div_q, div_d;
  logic [BW-1:0]  bit_q, bit_d;
  logic [W-1:0]   word_q, word_d;
  logic           last_q, last_d;
  logic           sclk_q, rclk_q, dio_q;
  logic           div_end;

  assign div_end = (div_q == DW'(CLK_DIV - 1));

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    word_d  = word_q;
    last_d  = last_q;
    done    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          word_d  = word;
          bit_d   = '0;
          div_d   = '0;
          state_d = ST_SH_LO;
        end
      end
      ST_SH_LO: begin
        if (div_end) begin
          div_d   = '0;
          state_d = ST_SH_HI;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      ST_SH_HI: begin
        if (div_end) begin
          div_d   = '0;
          last_d  = word_q[W-1];
          word_d  = {word_q[W-2:0], 1'b0};
          bit_d   = bit_q + 1'b1;
          state_d = (bit_q == BW'(W - 1)) ? ST_LATCH : ST_SH_LO;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      ST_LATCH: begin
        if (div_end) begin
          div_d   = '0;
          done    = 1'b1;
          state_d = ST_IDLE;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Pin registers are loaded from next-state so they line up with state_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      word_q  <= '0;
      last_q  <= 1'b0;
      sclk_q  <= 1'b0;
      rclk_q  <= 1'b0;
      dio_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      word_q  <= word_d;
      last_q  <= last_d;
      sclk_q  <= (state_d == ST_SH_HI);
      rclk_q  <= (state_d == ST_LATCH);
      dio_q   <= (state_d == ST_SH_LO || state_d == ST_SH_HI) ? word_d[W-1] : last_d;
    end
  end

  assign sclk = sclk_q;
  assign rclk = rclk_q;
  assign dio  = dio_q;

endmodule

// File: rtl/mfe_led7seg_74hc595_scanner.sv
// Self-refreshing multiplexed 7-segment driver: frame buffer plus digit scan
// (LOAD, shift/latch via mfe_74hc595_shifter, DWELL) over a 74HC595 chain.
module mfe_led7seg_74hc595_scanner
  import mfe_led7seg_pkg::*;
#(
  parameter int DIG_NUM     = 8,
  parameter int SEG_NUM     = 8,
  parameter int CLK_DIV     = 4,
  parameter int DWELL       = 1024,
  parameter bit DIG_ACT_LOW = 1'b1,
  parameter bit SEG_ACT_LOW = 1'b1,
  parameter bit SEL_FIRST   = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wr_en,
  input  logic [clogb2(DIG_NUM)-1:0]  wr_addr,
  input  logic [SEG_NUM-1:0]          wr_dat,
  input  logic                        enb,
  input  logic                        blank,
  output logic                        sclk,
  output logic                        rclk,
  output logic                        dio,
  output logic                        busy,
  output logic                        frame_done
);

  localparam int W   = DIG_NUM + SEG_NUM;
  localparam int AW  = clogb2(DIG_NUM);
  localparam int DWW = clogb2(DWELL);

  // ST_SH_LO here means "shifter running"; it covers SH_LO/SH_HI/LATCH.
  state_e             state_q, state_d;
  logic [AW-1:0]      dig_q, dig_d;
  logic [DWW-1:0]     dw_q, dw_d;
  logic               fd_q, fd_d;
  logic [SEG_NUM-1:0] fb_q [DIG_NUM];

  logic               start;
  logic               sh_done;
  logic               sh_dio;
  logic [SEG_NUM-1:0] seg_lit;
  logic [SEG_NUM-1:0] seg_pin;
  logic [DIG_NUM-1:0] sel_pin;
  logic [W-1:0]       word;

  always_comb begin
    seg_lit = '0;
    for (int d = 0; d < DIG_NUM; d++) begin
      if (dig_q == AW'(d)) seg_lit = fb_q[d];
    end
    if (blank) seg_lit = '0;
    for (int d = 0; d < DIG_NUM; d++) sel_pin[d] = pol_bit(dig_q == AW'(d), DIG_ACT_LOW);
    for (int s = 0; s < SEG_NUM; s++) seg_pin[s] = pol_bit(seg_lit[s], SEG_ACT_LOW);
    word = SEL_FIRST ? {sel_pin, seg_pin} : {seg_pin, sel_pin};
  end

  always_comb begin
    state_d = state_q;
    dig_d   = dig_q;
    dw_d    = dw_q;
    fd_d    = 1'b0;
    start   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (enb) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        start   = 1'b1;
        state_d = ST_SH_LO;
      end
      ST_SH_LO: begin
        if (sh_done) begin
          dw_d    = '0;
          fd_d    = (dig_q == AW'(DIG_NUM - 1));
          state_d = ST_DWELL;
        end
      end
      ST_DWELL: begin
        if (dw_q == DWW'(DWELL - 1)) begin
          dig_d = (dig_q == AW'(DIG_NUM - 1)) ? '0 : dig_q + 1'b1;
          if (enb) begin
            state_d = ST_LOAD;
          end else begin
            state_d = ST_IDLE;
            dig_d   = '0;
          end
        end else begin
          dw_d = dw_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      dig_q   <= '0;
      dw_q    <= '0;
      fd_q    <= 1'b0;
      for (int d = 0; d < DIG_NUM; d++) fb_q[d] <= '0;
    end else begin
      state_q <= state_d;
      dig_q   <= dig_d;
      dw_q    <= dw_d;
      fd_q    <= fd_d;
      // Out-of-range addresses match no entry and are dropped.
      for (int d = 0; d < DIG_NUM; d++) begin
        if (wr_en && wr_addr == AW'(d)) fb_q[d] <= wr_dat;
      end
    end
  end

  mfe_74hc595_shifter #(
    .W       (W),
    .CLK_DIV (CLK_DIV)
  ) u_shifter (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .word  (word),
    .done  (sh_done),
    .sclk  (sclk),
    .rclk  (rclk),
    .dio   (sh_dio)
  );

  // The shifter holds its last bit between digits; the pin parks low when idle.
  assign dio        = sh_dio & (state_q != ST_IDLE);
  assign busy       = (state_q != ST_IDLE);
  assign frame_done = fd_q;

endmodule

// File: doc/mfe_led7seg_74hc595_scanner.md
# mfe_led7seg_74hc595_scanner

Self-refreshing multiplexed 7-segment display driver for daisy-chained 74HC595 shift registers. It holds a DIG_NUM-entry frame buffer written by the host, and continuously scans digits without host involvement. Per digit it serialises a select+segment word on SCLK/DIO, pulses RCLK, then dwells. It sits between user logic (digit writes) and the board pins, and generalises the single-word controller to arbitrary digit/segment counts, polarity, bit order and refresh rate.

## Interface
- DIG_NUM, 8: number of digits, ≥2; also the digit-select bit count.
- SEG_NUM, 8: segments per digit, including DP.
- CLK_DIV, 4: SCLK half-period in clk cycles, ≥1.
- DWELL, 1024: clk cycles each digit stays latched before the next shift starts, ≥1.
- DIG_ACT_LOW, 1: 1 = the selected digit line is driven 0.
- SEG_ACT_LOW, 1: 1 = a lit segment is driven 0.
- SEL_FIRST, 1: 1 = shift word {sel, seg}; 0 = {seg, sel}. Both are MSB first.
- Derived: W = DIG_NUM+SEG_NUM (no padding); AW = clogb2(DIG_NUM).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- wr_en  in  1  frame-buffer write strobe.
- wr_addr  in  AW  digit index; values ≥ DIG_NUM are ignored.
- wr_dat  in  SEG_NUM  logical segment pattern, 1 = lit.
- enb  in  1  scan enable.
- blank  in  1  force all segments off in subsequently loaded words.
- sclk  out  1  74HC595 SHCP.
- rclk  out  1  74HC595 STCP.
- dio  out  1  74HC595 DS.
- busy  out  1  high in any state other than IDLE.
- frame_done  out  1  one-cycle pulse after the last digit latches.

## Operation
- Reset: all outputs 0; FSM in IDLE; dig_idx = 0; buffer cleared to 0 (all segments unlit).
- Buffer writes are accepted in any state and take effect the next cycle. A LOAD in the same cycle as a write to the same address uses the old value.
- States and transitions:
  - IDLE: waits for enb = 1, then goes to LOAD.
  - LOAD: runs 1 cycle.
    - Builds the word: sel = one-hot(dig_idx); seg = blank ? 0 : buf[dig_idx].
    - Applies polarity: invert sel if DIG_ACT_LOW; invert seg if SEG_ACT_LOW.
    - Orders the word per SEL_FIRST, clears bit_cnt, then goes to SH_LO.
  - SH_LO: runs CLK_DIV cycles with sclk = 0 and dio = current MSB, then goes to SH_HI.
  - SH_HI: runs CLK_DIV cycles with sclk = 1.
    - On exit: shift the word left and increment bit_cnt.
    - Next state: LATCH if bit_cnt reached W, otherwise SH_LO.
  - LATCH: runs CLK_DIV cycles with rclk = 1 and sclk = 0.
    - On exit, if dig_idx == DIG_NUM-1, frame_done pulses on the next cycle.
    - Then goes to DWELL.
  - DWELL: runs DWELL cycles.
    - On exit, dig_idx increments, wrapping from DIG_NUM-1 to 0.
    - Next state: LOAD if enb = 1; otherwise IDLE, with dig_idx forced to 0.
- Deasserting enb mid-digit never truncates a shift. The current digit completes through DWELL.
- dio is held at the last shifted bit outside SH_LO/SH_HI and returns to 0 in IDLE.
- blank is sampled only in LOAD.

## Timing
- The first SH_LO begins 2 cycles after enb rises in IDLE.
- dio is stable CLK_DIV cycles before each sclk rise and through the following SH_HI.
- Cycles per digit: T = 1 + 2·CLK_DIV·W + CLK_DIV + DWELL. With defaults, T = 1157.
- Frame period is DIG_NUM·T. frame_done pulses once per frame.
- sclk and rclk are never high simultaneously.
- rst mid-shift:
  - On the following cycle, outputs read 0 and the FSM is in IDLE.
  - The buffer is cleared.
  - Shift-register contents on the board are undefined until the next LATCH.

## Structure
- Shared package mfe_led7seg_pkg holds:
  - the clogb2 function;
  - the FSM state encoding (IDLE, LOAD, SH_LO, SH_HI, LATCH, DWELL);
  - the polarity helper for building the select/segment word.
- Sub-module mfe_74hc595_shifter is a generic W-bit serialiser.
  - Parameters: W, CLK_DIV.
  - Ports: start, word, done, sclk, rclk, dio.
  - It owns SH_LO/SH_HI/LATCH.
- The scanner owns the buffer, blank, dig_idx, DWELL counter and frame_done.

## Test plan
- Reset values: assert rst for 3 cycles mid-SH_HI.
  - Next cycle: sclk = rclk = dio = busy = frame_done = 0.
  - After restart, every digit shows all segments off.
- Single digit, config DIG_NUM=4, SEG_NUM=8, CLK_DIV=1, DWELL=4, active-low, SEL_FIRST=1:
  - Stimulus: write addr0 = 0x3F, then enb = 1.
  - dio sampled on sclk rises = 12'b1110_1100_0000.
  - rclk high for 1 cycle; 30 cycles per digit; frame_done every 120 cycles.
- Order/polarity: same config with SEL_FIRST=0, DIG_ACT_LOW=0, SEG_ACT_LOW=0.
  - Digit 2 with buf = 0x81 shifts 12'b1000_0001_0100.
- Blank and write race:
  - Assert blank: every shifted seg field = 0xFF (active-low).
  - Write addr1 in digit 1's LOAD cycle: the old value is shifted; the new value appears next frame.
- enb drop mid-shift of digit 2: digit 2 completes (LATCH and DWELL), then busy = 0 and dig_idx = 0. Re-enabling starts at digit 0.
- wr_addr = 5 with DIG_NUM = 4: no buffer change across a full frame.
